trng_byte_collector: RTL and testbench

Downstream consumer of the SR-latch entropy network. Samples its single random output bit each clock while enabled and optionally debiases the bits with a von Neumann extractor. Assembles accepted bits into bytes and buffers them in a small first-word-fall-through FIFO with a valid/ready read port. A repetition-count health test latches a sticky fault and halts collection when the raw source sticks.

---
 rtl/trng_byte_collector_if.sv | 24 ++
 rtl/trng_byte_collector.sv | 124 ++++++++++++
 tb/tb_trng_byte_collector.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_byte_collector_if.sv
// Byte-collector bus: raw entropy bit input plus FWFT byte read port.
// The master drives raw bits and the read-ready; the slave (collector) returns bytes and status.
interface trng_byte_collector_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          bit_in;
    logic                          bit_valid;
    logic                          byte_ready;
    logic [7:0]                    byte_out;
    logic                          byte_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          stuck;

    modport master (
        output bit_in, bit_valid, byte_ready,
        input  byte_out, byte_valid, fifo_count, overflow, stuck
    );

    modport slave (
        input  bit_in, bit_valid, byte_ready,
        output byte_out, byte_valid, fifo_count, overflow, stuck
    );
endinterface

// File: rtl/trng_byte_collector.sv
// TRNG byte collector: repetition-count health test, optional von Neumann debias
// (macro TRNG_DEBIAS_EN), MSB-first byte assembly and a FWFT byte FIFO.
module trng_byte_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trng_byte_collector_if.slave bus
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [7:0] REP_LIM_B = 8'(REP_LIMIT);

    function automatic logic [7:0] run_sat_inc(input logic [7:0] run);
        return (run >= REP_LIM_B) ? REP_LIM_B : run + 8'd1;
    endfunction

    logic          r_stuck;
    logic          r_ovf;
    logic          r_last;
    logic [7:0]    r_run;
    logic [6:0]    r_shift;
    logic [2:0]    r_cnt;
    logic [CW-1:0] r_wr;
    logic [CW-1:0] r_rd;
    logic [7:0]    r_mem [FIFO_DEPTH];

    logic          w_take;
    logic [7:0]    w_run_next;
    logic          w_trip;
    logic          w_proc;
    logic          w_acc;
    logic          w_acc_bit;
    logic          w_byte_done;
    logic [7:0]    w_byte;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_rd;
    logic          w_push;
    logic          w_drop;

    // Health test on raw bits: a zero run counter means no previous bit yet.
    assign w_take     = bus.bit_valid && !r_stuck;
    assign w_run_next = (r_run != 8'd0 && bus.bit_in == r_last) ? run_sat_inc(r_run) : 8'd1;
    assign w_trip     = w_take && (w_run_next == REP_LIM_B);
    assign w_proc     = w_take && !w_trip;

`ifdef TRNG_DEBIAS_EN
    logic r_pair_full;
    logic r_pair_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_full <= 1'b0;
            r_pair_bit  <= 1'b0;
        end else if (w_proc) begin
            r_pair_full <= !r_pair_full;
            if (!r_pair_full)
                r_pair_bit <= bus.bit_in;
        end
    end

    // 10 yields 1 and 01 yields 0: the accepted bit is the first of the pair.
    assign w_acc     = w_proc && r_pair_full && (r_pair_bit != bus.bit_in);
    assign w_acc_bit = r_pair_bit;
`else
    assign w_acc     = w_proc;
    assign w_acc_bit = bus.bit_in;
`endif

    assign w_byte_done = w_acc && (r_cnt == 3'd7);
    assign w_byte      = {r_shift, w_acc_bit};

    assign w_count = r_wr - r_rd;
    assign w_full  = (w_count == CW'(FIFO_DEPTH));
    assign w_empty = (w_count == '0);
    assign w_rd    = !w_empty && bus.byte_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push  = w_byte_done && (!w_full || w_rd);
    assign w_drop  = w_byte_done && w_full && !w_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck <= 1'b0;
            r_ovf   <= 1'b0;
            r_last  <= 1'b0;
            r_run   <= 8'd0;
            r_shift <= 7'd0;
            r_cnt   <= 3'd0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_take) begin
                r_run  <= w_run_next;
                r_last <= bus.bit_in;
            end
            if (w_trip)
                r_stuck <= 1'b1;
            if (w_acc) begin
                r_shift <= {r_shift[5:0], w_acc_bit};
                r_cnt   <= r_cnt + 3'd1;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            if (w_push)
                r_wr <= r_wr + CW'(1);
            if (w_rd)
                r_rd <= r_rd + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= w_byte;
    end

    assign bus.byte_valid = !w_empty;
    assign bus.byte_out   = w_empty ? 8'd0 : r_mem[r_rd[AW-1:0]];
    assign bus.fifo_count = w_count;
    assign bus.overflow   = r_ovf;
    assign bus.stuck      = r_stuck;
endmodule

// File: tb/tb_trng_byte_collector.sv
// Bench for trng_byte_collector: vector table, directed corner sequences, randomized model check.
module tb_trng_byte_collector;
    localparam int DEPTH = 4;
    localparam int REP   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trng_byte_collector_if #(.FIFO_DEPTH(DEPTH)) bus ();

    trng_byte_collector #(.FIFO_DEPTH(DEPTH), .REP_LIMIT(REP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       b;
        logic       v;
        logic       r;
        logic       ev;
        logic [7:0] eo;
        int         ec;
    } vec_t;

    vec_t tbl[$];
    bit   raw_q[$];

    // Behavioural reference model state
    bit         m_have_last, m_last, m_stuck, m_ovf, m_pair_full, m_pair_bit;
    int         m_run;
    bit         m_bits[$];
    logic [7:0] m_fifo[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int ev, input int eo, input int ec,
                           input int eovf, input int estk);
        chk({tag, ".byte_valid"}, int'(bus.byte_valid), ev);
        chk({tag, ".byte_out"},   int'(bus.byte_out),   eo);
        chk({tag, ".fifo_count"}, int'(bus.fifo_count), ec);
        chk({tag, ".overflow"},   int'(bus.overflow),   eovf);
        chk({tag, ".stuck"},      int'(bus.stuck),      estk);
    endtask

    task automatic step(input logic b, input logic v, input logic r);
        bus.bit_in     = b;
        bus.bit_valid  = v;
        bus.byte_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_have_last = 0; m_last = 0; m_stuck = 0; m_ovf = 0;
        m_pair_full = 0; m_pair_bit = 0; m_run = 0;
        m_bits.delete();
        m_fifo.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.bit_in = 0; bus.bit_valid = 0; bus.byte_ready = 0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Raw bit sequence that yields exactly the given byte through the configured path
    task automatic make_raw(input logic [7:0] b);
        raw_q.delete();
        for (int i = 7; i >= 0; i--) begin
`ifdef TRNG_DEBIAS_EN
            raw_q.push_back(b[i]);
            raw_q.push_back(~b[i]);
`else
            raw_q.push_back(b[i]);
`endif
        end
    endtask

    task automatic feed_byte(input logic [7:0] b, input logic ready_last);
        make_raw(b);
        for (int i = 0; i < raw_q.size() - 1; i++)
            step(raw_q[i], 1'b1, 1'b0);
        step(raw_q[raw_q.size()-1], 1'b1, ready_last);
    endtask

    task automatic drain_one(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, int'(bus.byte_valid), 1);
        chk({tag, ".data"},  int'(bus.byte_out),   int'(exp));
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic model_step(input bit b, input bit v, input bit r);
        bit         rd;
        bit         wr;
        logic [7:0] d;
        rd = (m_fifo.size() > 0) && r;
        wr = 0;
        d  = 0;
        if (v && !m_stuck) begin
            m_run = (m_have_last && b == m_last) ? m_run + 1 : 1;
            if (m_run > REP) m_run = REP;
            m_have_last = 1;
            m_last      = b;
            if (m_run >= REP) begin
                m_stuck = 1;
            end else begin
`ifdef TRNG_DEBIAS_EN
                if (!m_pair_full) begin
                    m_pair_full = 1;
                    m_pair_bit  = b;
                end else begin
                    m_pair_full = 0;
                    if (m_pair_bit != b) m_bits.push_back(m_pair_bit);
                end
`else
                m_bits.push_back(b);
`endif
                if (m_bits.size() == 8) begin
                    for (int k = 0; k < 8; k++) d = {d[6:0], m_bits[k]};
                    m_bits.delete();
                    wr = 1;
                end
            end
        end
        if (rd) void'(m_fifo.pop_front());
        if (wr) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else                       m_ovf = 1;
        end
    endtask

    initial begin
        logic [19:0] pat;
        logic [7:0]  a5;
        bit          rb, rv, rr, prevb;
        int          exp_cnt;

        bus.bit_in = 0; bus.bit_valid = 0; bus.byte_ready = 0;
        do_reset();
        chk_out("reset", 0, 0, 0, 0, 0);

        // ---- Table-driven first byte ----
`ifdef TRNG_DEBIAS_EN
        pat = 20'b10_01_11_10_00_10_01_01_10_01;
        for (int i = 19; i >= 0; i--)
            tbl.push_back('{pat[i], 1'b1, 1'b0, (i == 0), (i == 0) ? 8'hB2 : 8'h00, (i == 0) ? 1 : 0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0});
`else
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--)
            tbl.push_back('{a5[i], 1'b1, 1'b0, (i == 0), (i == 0) ? 8'hA5 : 8'h00, (i == 0) ? 1 : 0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].v, tbl[i].r);
            chk($sformatf("tbl[%0d].valid", i), int'(bus.byte_valid), int'(tbl[i].ev));
            chk($sformatf("tbl[%0d].out", i),   int'(bus.byte_out),   int'(tbl[i].eo));
            chk($sformatf("tbl[%0d].count", i), int'(bus.fifo_count), tbl[i].ec);
        end

        // ---- Overflow: five bytes into a depth-4 FIFO, then drain ----
        do_reset();
        feed_byte(8'h12, 1'b0);
        feed_byte(8'h34, 1'b0);
        feed_byte(8'h56, 1'b0);
        feed_byte(8'h78, 1'b0);
        chk("ovf.before", int'(bus.overflow), 0);
        feed_byte(8'h9A, 1'b0);
        chk_out("ovf.full", 1, 8'h12, 4, 1, 0);
        drain_one("ovf.d0", 8'h12);
        drain_one("ovf.d1", 8'h34);
        drain_one("ovf.d2", 8'h56);
        drain_one("ovf.d3", 8'h78);
        chk_out("ovf.empty", 0, 0, 0, 1, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("ovf.ready_when_empty", int'(bus.fifo_count), 0);

        // ---- Simultaneous write and read while full ----
        do_reset();
        feed_byte(8'h21, 1'b0);
        feed_byte(8'h43, 1'b0);
        feed_byte(8'h65, 1'b0);
        feed_byte(8'h87, 1'b0);
        feed_byte(8'hC3, 1'b1);
        chk_out("fullrw", 1, 8'h43, 4, 0, 0);
        drain_one("fullrw.d0", 8'h43);
        drain_one("fullrw.d1", 8'h65);
        drain_one("fullrw.d2", 8'h87);
        drain_one("fullrw.d3", 8'hC3);
        chk("fullrw.empty", int'(bus.byte_valid), 0);

        // ---- Repetition test: 32 raw ones ----
        do_reset();
        for (int i = 0; i < REP - 1; i++) step(1'b1, 1'b1, 1'b0);
        chk("stuck.before_limit", int'(bus.stuck), 0);
        step(1'b1, 1'b1, 1'b0);
`ifdef TRNG_DEBIAS_EN
        exp_cnt = 0;
        chk_out("stuck.trip", 0, 0, 0, 0, 1);
`else
        exp_cnt = 3;
        chk_out("stuck.trip", 1, 8'hFF, 3, 0, 1);
`endif
        for (int i = 0; i < 16; i++) step(1'(i & 1), 1'b1, 1'b0);
        chk("stuck.hold_count", int'(bus.fifo_count), exp_cnt);
        chk("stuck.hold_flag",  int'(bus.stuck), 1);
        for (int i = 0; i < exp_cnt; i++) drain_one($sformatf("stuck.d%0d", i), 8'hFF);
        chk("stuck.drained", int'(bus.byte_valid), 0);

        // ---- Reset mid-byte with two bytes queued ----
        do_reset();
        feed_byte(8'h3C, 1'b0);
        feed_byte(8'h5A, 1'b0);
        make_raw(8'hE7);
        for (int i = 0; i < 5; i++) step(raw_q[i], 1'b1, 1'b0);
        bus.bit_valid = 0;
        rst_n = 1'b0;
        #2;
        chk_out("midrst.async", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        feed_byte(8'h96, 1'b0);
        chk_out("midrst.after", 1, 8'h96, 1, 0, 0);
        drain_one("midrst.d0", 8'h96);
        chk("midrst.single", int'(bus.byte_valid), 0);

        // ---- Randomized run against the reference model ----
        do_reset();
        prevb = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i < 600) rb = 1'($urandom_range(0, 1));
            else         rb = ($urandom_range(0, 15) == 0) ? ~prevb : prevb;
            prevb = rb;
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 3);
            model_step(rb, rv, rr);
            step(rb, rv, rr);
            chk("rnd.valid",    int'(bus.byte_valid), int'(m_fifo.size() > 0));
            chk("rnd.out",      int'(bus.byte_out),   (m_fifo.size() > 0) ? int'(m_fifo[0]) : 0);
            chk("rnd.count",    int'(bus.fifo_count), m_fifo.size());
            chk("rnd.overflow", int'(bus.overflow),   int'(m_ovf));
            chk("rnd.stuck",    int'(bus.stuck),      int'(m_stuck));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
